uart_tx_ctrl: RTL and testbench

Sequencing controller for the UART transmit register datapath (holding register TBR plus 10-bit shift register TSR). It generates the baud timing and accepts byte writes from the CPU/Forth core. It drives the datapath strobes (tbr_en, load, shift, set, clear_valid) so that each byte goes out as a frame of 1 start bit, 8 data bits (LSB first) and 1 stop bit. It sits between the core's I/O write port and the transmit register.

---
 rtl/uart_tx_ctrl_if.sv | 34 +++
 rtl/uart_tx_ctrl.sv | 122 ++++++++++++
 tb/tb_uart_tx_ctrl.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_ctrl_if.sv
// Handshake and strobe bundle between the UART transmit controller and the
// CPU write port / TBR+TSR datapath.
interface uart_tx_ctrl_if;
    logic wr_en;
    logic wr_ready;
    logic tbr_valid_i;
    logic tbr_en;
    logic load;
    logic shift;
    logic set;
    logic clear_valid;

    modport master (
        input  wr_en,
        input  tbr_valid_i,
        output wr_ready,
        output tbr_en,
        output load,
        output shift,
        output set,
        output clear_valid
    );

    modport slave (
        output wr_en,
        output tbr_valid_i,
        input  wr_ready,
        input  tbr_en,
        input  load,
        input  shift,
        input  set,
        input  clear_valid
    );
endinterface

// File: rtl/uart_tx_ctrl.sv
// UART transmit sequencer: baud timing plus TBR/TSR strobes producing
// start + 8 data (LSB first) + stop frames.
module uart_tx_ctrl #(
    parameter int DIV_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tx_en,
    input  logic [DIV_W-1:0] div,
    uart_tx_ctrl_if.master   bus,
    output logic             tx_busy,
    output logic             tx_done
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_SEND = 2'd2
    } state_t;

    state_t           state_r, state_s;
    logic [DIV_W-1:0] baud_cnt_r, baud_cnt_s;
    logic [DIV_W-1:0] div_q_r, div_q_s;
    logic [3:0]       bit_cnt_r, bit_cnt_s;
    logic             terminal_s;
    logic             wr_ready_s, tbr_en_s, load_s, shift_s, set_s, clear_s;
    logic             busy_s, done_s;

    // Divisors below 2 would leave no room for a counted bit period.
    function automatic logic [DIV_W-1:0] clamp_div(input logic [DIV_W-1:0] d);
        if (d < DIV_W'(2)) begin
            return DIV_W'(2);
        end else begin
            return d;
        end
    endfunction

    // State and counter registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r    <= ST_IDLE;
            baud_cnt_r <= {DIV_W{1'b0}};
            bit_cnt_r  <= 4'd0;
            div_q_r    <= DIV_W'(2);
        end else begin
            state_r    <= state_s;
            baud_cnt_r <= baud_cnt_s;
            bit_cnt_r  <= bit_cnt_s;
            div_q_r    <= div_q_s;
        end
    end

    // Next-state, counter updates and strobe decode.
    always_comb begin
        state_s    = state_r;
        baud_cnt_s = baud_cnt_r;
        bit_cnt_s  = bit_cnt_r;
        div_q_s    = div_q_r;
        load_s     = 1'b0;
        shift_s    = 1'b0;
        set_s      = 1'b1;
        clear_s    = 1'b0;
        busy_s     = 1'b0;
        done_s     = 1'b0;
        terminal_s = (baud_cnt_r == (div_q_r - DIV_W'(1)));
        // TBR is still valid during LOAD, so the state term only guards the corner.
        wr_ready_s = !bus.tbr_valid_i && (state_r != ST_LOAD);
        tbr_en_s   = bus.wr_en && wr_ready_s;

        case (state_r)
            ST_IDLE: begin
                if (tx_en && bus.tbr_valid_i) begin
                    state_s = ST_LOAD;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_LOAD: begin
                load_s     = 1'b1;
                clear_s    = 1'b1;
                busy_s     = 1'b1;
                div_q_s    = clamp_div(div);
                baud_cnt_s = {DIV_W{1'b0}};
                bit_cnt_s  = 4'd0;
                state_s    = ST_SEND;
            end
            ST_SEND: begin
                set_s  = 1'b0;
                busy_s = 1'b1;
                if (terminal_s) begin
                    baud_cnt_s = {DIV_W{1'b0}};
                    if (bit_cnt_r == 4'd9) begin
                        done_s = 1'b1;
                        if (tx_en && bus.tbr_valid_i) begin
                            state_s = ST_LOAD;
                        end else begin
                            state_s = ST_IDLE;
                        end
                    end else begin
                        shift_s   = 1'b1;
                        bit_cnt_s = bit_cnt_r + 4'd1;
                    end
                end else begin
                    baud_cnt_s = baud_cnt_r + DIV_W'(1);
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    assign bus.wr_ready    = wr_ready_s;
    assign bus.tbr_en      = tbr_en_s;
    assign bus.load        = load_s;
    assign bus.shift       = shift_s;
    assign bus.set         = set_s;
    assign bus.clear_valid = clear_s;
    assign tx_busy         = busy_s;
    assign tx_done         = done_s;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Bench for uart_tx_ctrl: models the TBR/TSR datapath, queues accepted bytes
// and checks every cycle of the transmitted line against a frame-level model.
module tb_uart_tx_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        tx_en = 1'b0;
    logic [15:0] div = 16'd4;
    logic        tx_busy, tx_done;
    logic [7:0]  data_in = 8'h00;

    uart_tx_ctrl_if bus ();

    uart_tx_ctrl #(.DIV_W(16)) dut (
        .clk     (clk),
        .reset   (reset),
        .tx_en   (tx_en),
        .div     (div),
        .bus     (bus.master),
        .tx_busy (tx_busy),
        .tx_done (tx_done)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    logic [7:0] exp_q[$];

    // Environment model of the holding and shift registers.
    logic [7:0] tbr_q;
    logic       tbr_valid_dp;
    logic [9:0] tsr;
    logic       tx;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            tbr_q        <= 8'h00;
            tbr_valid_dp <= 1'b0;
            tsr          <= 10'h3FF;
        end else begin
            if (bus.clear_valid) tbr_valid_dp <= 1'b0;
            else if (bus.tbr_en) begin
                tbr_valid_dp <= 1'b1;
                tbr_q        <= data_in;
            end
            if (bus.load) tsr <= {1'b1, tbr_q, 1'b0};
            else if (bus.shift) tsr <= {1'b1, tsr[9:1]};
        end
    end

    assign bus.tbr_valid_i = tbr_valid_dp;
    assign tx = bus.set ? 1'b1 : tsr[0];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic int eff_div(input logic [15:0] d);
        return (d < 16'd2) ? 2 : int'(d);
    endfunction

    // Frame-level line model state, visible to the stimulus for draining.
    logic rx_on = 1'b0;
    logic load_wait = 1'b0;
    logic start_next = 1'b0;

    // Monitor: one pass per cycle at the falling edge.
    initial begin : monitor
        int cnt, d, d_next, k, pos;
        logic [7:0] b;
        logic exp_tx, decision;
        cnt = 0; d = 2; d_next = 2; b = 8'h00;
        forever begin
            @(negedge clk);
            if (reset) begin
                chk("reset_outputs", {tx, tx_busy, bus.load, bus.shift, bus.clear_valid, tx_done, bus.tbr_en},
                    7'b1000000);
                rx_on = 1'b0; load_wait = 1'b0; start_next = 1'b0;
                exp_q.delete();
                continue;
            end
            chk("wr_ready", bus.wr_ready, !tbr_valid_dp);
            chk("tbr_en", bus.tbr_en, bus.wr_en && !tbr_valid_dp);
            chk("tbr_en_with_clear", bus.tbr_en && bus.clear_valid, 1'b0);
            decision = 1'b0;
            if (start_next) begin
                start_next = 1'b0;
                chk("byte_pending_at_start", exp_q.size() != 0, 1'b1);
                b = (exp_q.size() != 0) ? exp_q.pop_front() : 8'h00;
                rx_on = 1'b1; cnt = 0; d = d_next;
            end
            if (rx_on) begin
                k = cnt / d; pos = cnt % d;
                exp_tx = (k == 0) ? 1'b0 : (k == 9) ? 1'b1 : b[k-1];
                chk("tx_bit", tx, exp_tx);
                chk("busy_send", tx_busy, 1'b1);
                chk("strobes_send", {bus.load, bus.clear_valid, bus.set, bus.shift, tx_done},
                    {3'b000, (pos == d-1) && (k < 9), (pos == d-1) && (k == 9)});
                if (cnt == 10*d - 1) begin
                    rx_on = 1'b0; decision = 1'b1;
                end else begin
                    cnt++;
                end
            end else if (load_wait) begin
                chk("tx_load", tx, 1'b1);
                chk("busy_load", tx_busy, 1'b1);
                chk("strobes_load", {bus.load, bus.clear_valid, bus.set, bus.shift, tx_done}, 5'b11100);
                d_next = eff_div(div);
                load_wait = 1'b0; start_next = 1'b1;
            end else begin
                chk("tx_idle", tx, 1'b1);
                chk("busy_idle", tx_busy, 1'b0);
                chk("strobes_idle", {bus.load, bus.clear_valid, bus.set, bus.shift, tx_done}, 5'b00100);
                decision = 1'b1;
            end
            if (decision && tbr_valid_dp && tx_en) load_wait = 1'b1;
        end
    end

    task automatic cyc(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wr(input logic [7:0] v);
        bus.wr_en = 1'b1;
        data_in   = v;
        if (!tbr_valid_dp) exp_q.push_back(v);
        cyc(1);
        bus.wr_en = 1'b0;
    endtask

    initial begin : stimulus
        int r;
        bus.wr_en = 1'b0;
        cyc(3);
        reset = 1'b0;
        cyc(2);

        // Single frame at div=4.
        tx_en = 1'b1; div = 16'd4;
        wr(8'hA5);
        cyc(46);

        // Second byte buffered mid-frame, third dropped while TBR is full.
        wr(8'h3C);
        cyc(8);
        wr(8'hC3);
        cyc(2);
        wr(8'h99);
        cyc(95);

        // Divisors 0 and 1 behave as 2; a mid-frame change is ignored.
        div = 16'd0; wr(8'h12); cyc(8); div = 16'd7; cyc(20);
        div = 16'd1; wr(8'h34); cyc(25);

        // Enable gating.
        div = 16'd3;
        tx_en = 1'b0; wr(8'h55); cyc(20);
        tx_en = 1'b1; cyc(40);
        wr(8'h66); cyc(10); wr(8'h77); cyc(5);
        tx_en = 1'b0; cyc(50);
        tx_en = 1'b1; cyc(40);

        // Reset during data bit 3.
        div = 16'd4;
        wr(8'h5A); cyc(18);
        reset = 1'b1; cyc(2);
        reset = 1'b0; cyc(1);
        wr(8'hF0); cyc(50);

        // Randomised traffic.
        for (int i = 0; i < 500; i++) begin
            r = $urandom_range(0, 9);
            if (r < 4) begin
                wr(8'($urandom));
            end else if (r == 4) begin
                div = 16'($urandom_range(0, 6));
                cyc(1);
            end else if (r == 5) begin
                tx_en = ($urandom_range(0, 3) != 0);
                cyc(1);
            end else begin
                cyc(1);
            end
        end

        tx_en = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            if (exp_q.size() == 0 && !tbr_valid_dp && !rx_on && !load_wait && !start_next) break;
            cyc(1);
        end
        chk("drain_queue", exp_q.size(), 0);
        chk("drain_idle", {tbr_valid_dp, rx_on, load_wait, start_next}, 4'b0000);
        cyc(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
